// File: rtl/branch_resolve_queue.sv
// In-order branch tracker: holds predictions until execute resolves them, drives the predictor
// update strobe and the mispredict flush/redirect. Optional counters under `BRQ_STATS_EN`.
`timescale 1ns/1ps
module branch_resolve_queue #(
    parameter int DEPTH    = 8,
    parameter int GHR_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [31:0]                push_pc,
    input  logic                       push_pred_taken,
    input  logic [31:0]                push_pred_target,
    input  logic [GHR_BITS-1:0]        push_ghr,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic [31:0]                resolve_target,
    output logic                       upd_valid,
    output logic [31:0]                upd_pc,
    output logic                       upd_taken,
    output logic [GHR_BITS-1:0]        upd_ghr,
    output logic                       mispredict,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]                stat_branches,
    output logic [31:0]                stat_mispredicts
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]         pc;
        logic                taken;
        logic [31:0]         target;
        logic [GHR_BITS-1:0] ghr;
    } entry_t;

    typedef enum logic {ST_RUN, ST_RECOVER} state_t;

    entry_t              ent_q [DEPTH];
    entry_t              ent_d [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    state_t              state_q, state_d;
    logic                upd_valid_q, upd_valid_d;
    logic [31:0]         upd_pc_q, upd_pc_d;
    logic                upd_taken_q, upd_taken_d;
    logic [GHR_BITS-1:0] upd_ghr_q, upd_ghr_d;
    logic                mispredict_q, mispredict_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;
    logic                err_q, err_d;

    entry_t head;
    logic   pop, mis, push_fire;

    always_comb begin
        head       = ent_q[rd_ptr_q];
        push_ready = (state_q == ST_RUN) && (count_q < CW'(DEPTH));
        pop        = resolve_valid && (count_q != '0);
        mis        = pop && ((head.taken != resolve_taken) ||
                             (resolve_taken && (head.target != resolve_target)));
        // A push in the mispredict cycle is on the wrong path and is dropped.
        push_fire  = push_valid && push_ready && !mis;

        ent_d         = ent_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        state_d       = mis ? ST_RECOVER : ST_RUN;
        upd_valid_d   = pop;
        upd_pc_d      = pop ? head.pc : upd_pc_q;
        upd_taken_d   = pop ? resolve_taken : upd_taken_q;
        upd_ghr_d     = pop ? head.ghr : upd_ghr_q;
        mispredict_d  = mis;
        redirect_pc_d = redirect_pc_q;
        err_d         = err_q | (resolve_valid && (count_q == '0));

        if (push_fire) begin
            ent_d[wr_ptr_q] = '{pc: push_pc, taken: push_pred_taken,
                                target: push_pred_target, ghr: push_ghr};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (mis) begin
            redirect_pc_d = resolve_taken ? resolve_target : head.pc + 32'd4;
            rd_ptr_d      = wr_ptr_q;
            count_d       = '0;
        end else begin
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_RUN;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_ghr_q     <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_ghr_q     <= upd_ghr_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
        end
    end

    // Entry payload needs no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign upd_valid     = upd_valid_q;
    assign upd_pc        = upd_pc_q;
    assign upd_taken     = upd_taken_q;
    assign upd_ghr       = upd_ghr_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign count         = count_q;
    assign err_underflow = err_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = (pop && (stat_br_q != '1))  ? stat_br_q + 32'd1  : stat_br_q;
        stat_mis_d = (mis && (stat_mis_q != '1)) ? stat_mis_q + 32'd1 : stat_mis_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, corner sequences, and a
// queue-based reference model driven with random traffic.
`timescale 1ns/1ps
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;
    localparam int GB    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid, push_pred_taken, resolve_valid, resolve_taken;
    logic [31:0] push_pc, push_pred_target, resolve_target;
    logic [GB-1:0] push_ghr;
    logic        push_ready, upd_valid, upd_taken, mispredict, err_underflow;
    logic [31:0] upd_pc, redirect_pc;
    logic [GB-1:0] upd_ghr;
    logic [$clog2(DEPTH):0] count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .GHR_BITS(GB)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
        .push_ghr(push_ghr),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count),
        .err_underflow(err_underflow)
`ifdef BRQ_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [GB-1:0] ghr;
    } br_t;

    br_t         mq[$];
    logic [31:0] m_upc, m_redir, m_sb, m_sm;
    logic        m_utk, m_err, m_rec;
    logic [GB-1:0] m_ughr;

    task automatic do_reset();
        reset = 1'b1;
        push_valid = 0; push_pc = 0; push_pred_taken = 0; push_pred_target = 0; push_ghr = 0;
        resolve_valid = 0; resolve_taken = 0; resolve_target = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        mq.delete();
        m_upc = 0; m_redir = 0; m_utk = 0; m_ughr = 0; m_err = 0; m_rec = 0; m_sb = 0; m_sm = 0;
    endtask

    // One clock of stimulus; the model applies the queue rules and everything is compared.
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic ptk,
                       input logic [31:0] ptgt, input logic [GB-1:0] pghr,
                       input logic rv, input logic rtk, input logic [31:0] rtgt);
        br_t e;
        bit  mis, exp_ready, exp_uv;
        push_valid = pv; push_pc = ppc; push_pred_taken = ptk; push_pred_target = ptgt;
        push_ghr = pghr; resolve_valid = rv; resolve_taken = rtk; resolve_target = rtgt;
        exp_ready = !m_rec && (mq.size() < DEPTH);
        #1;
        chk("push_ready", {31'd0, push_ready}, {31'd0, exp_ready});
        @(posedge clk); #1;
        mis = 0; exp_uv = 0;
        if (rv) begin
            if (mq.size() == 0) m_err = 1;
            else begin
                e = mq.pop_front();
                exp_uv = 1; m_upc = e.pc; m_utk = rtk; m_ughr = e.ghr;
                if (m_sb != 32'hFFFF_FFFF) m_sb++;
                mis = (e.tk != rtk) || (rtk && e.tgt != rtgt);
                if (mis) begin
                    m_redir = rtk ? rtgt : e.pc + 32'd4;
                    mq.delete();
                    if (m_sm != 32'hFFFF_FFFF) m_sm++;
                end
            end
        end
        if (pv && exp_ready && !mis) mq.push_back('{ppc, ptk, ptgt, pghr});
        m_rec = mis;
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, exp_uv});
        chk("upd_pc", upd_pc, m_upc);
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, m_utk});
        chk("upd_ghr", {24'd0, upd_ghr}, {24'd0, m_ughr});
        chk("mispredict", {31'd0, mispredict}, {31'd0, mis});
        chk("redirect_pc", redirect_pc, m_redir);
        chk("count", {28'd0, count}, mq.size());
        chk("err_underflow", {31'd0, err_underflow}, {31'd0, m_err});
`ifdef BRQ_STATS_EN
        chk("stat_branches", stat_branches, m_sb);
        chk("stat_mispredicts", stat_mispredicts, m_sm);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic pv; logic [31:0] ppc; logic ptk; logic [31:0] ptgt; logic [GB-1:0] pghr;
        logic rv; logic rtk; logic [31:0] rtgt;
        logic e_ready; logic e_uv; logic [31:0] e_upc; logic e_utk; logic [GB-1:0] e_ughr;
        logic e_mis; logic [31:0] e_redir; int e_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] pc, tgt, rtgt;
        logic        tk, rtk;

        tbl[0] = '{1, 32'h100, 1, 32'h200, 8'hA5, 0, 0, 32'h0,   1, 0, 32'h0,   0, 8'h00, 0, 32'h0,   1};
        tbl[1] = '{0, 32'h0,   0, 32'h0,   8'h00, 1, 1, 32'h200, 1, 1, 32'h100, 1, 8'hA5, 0, 32'h0,   0};
        tbl[2] = '{1, 32'h300, 0, 32'h0,   8'h11, 0, 0, 32'h0,   1, 0, 32'h100, 1, 8'hA5, 0, 32'h0,   1};
        tbl[3] = '{1, 32'h304, 0, 32'h0,   8'h12, 0, 0, 32'h0,   1, 0, 32'h100, 1, 8'hA5, 0, 32'h0,   2};
        tbl[4] = '{1, 32'h308, 0, 32'h0,   8'h13, 0, 0, 32'h0,   1, 0, 32'h100, 1, 8'hA5, 0, 32'h0,   3};
        tbl[5] = '{1, 32'h30C, 0, 32'h0,   8'h14, 1, 1, 32'h400, 1, 1, 32'h300, 1, 8'h11, 1, 32'h400, 0};
        tbl[6] = '{1, 32'h500, 0, 32'h0,   8'h15, 0, 0, 32'h0,   0, 0, 32'h300, 1, 8'h11, 0, 32'h400, 0};
        tbl[7] = '{1, 32'hFFFF_FFFC, 1, 32'h10, 8'h33, 0, 0, 32'h0, 1, 0, 32'h300, 1, 8'h11, 0, 32'h400, 1};
        tbl[8] = '{0, 32'h0,   0, 32'h0,   8'h00, 1, 0, 32'h0,   1, 1, 32'hFFFF_FFFC, 0, 8'h33, 1, 32'h0, 0};
        tbl[9] = '{0, 32'h0,   0, 32'h0,   8'h00, 0, 0, 32'h0,   0, 0, 32'hFFFF_FFFC, 0, 8'h33, 0, 32'h0, 0};

        do_reset();
        chk("rst count", {28'd0, count}, 32'd0);
        chk("rst upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst upd_pc", upd_pc, 32'd0);
        chk("rst err", {31'd0, err_underflow}, 32'd0);
        chk("rst push_ready", {31'd0, push_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            push_valid = tbl[i].pv; push_pc = tbl[i].ppc; push_pred_taken = tbl[i].ptk;
            push_pred_target = tbl[i].ptgt; push_ghr = tbl[i].pghr;
            resolve_valid = tbl[i].rv; resolve_taken = tbl[i].rtk; resolve_target = tbl[i].rtgt;
            #1;
            chk($sformatf("t%0d push_ready", i), {31'd0, push_ready}, {31'd0, tbl[i].e_ready});
            @(posedge clk); #1;
            chk($sformatf("t%0d upd_valid", i), {31'd0, upd_valid}, {31'd0, tbl[i].e_uv});
            chk($sformatf("t%0d upd_pc", i), upd_pc, tbl[i].e_upc);
            chk($sformatf("t%0d upd_taken", i), {31'd0, upd_taken}, {31'd0, tbl[i].e_utk});
            chk($sformatf("t%0d upd_ghr", i), {24'd0, upd_ghr}, {24'd0, tbl[i].e_ughr});
            chk($sformatf("t%0d mispredict", i), {31'd0, mispredict}, {31'd0, tbl[i].e_mis});
            chk($sformatf("t%0d redirect_pc", i), redirect_pc, tbl[i].e_redir);
            chk($sformatf("t%0d count", i), {28'd0, count}, tbl[i].e_cnt);
        end

        // Full queue: a push alongside a correct resolve is still refused.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 32'h2000 + 32'(i) * 4, 0, 32'h0, GB'(i), 0, 0, 32'h0);
        chk("full count", {28'd0, count}, 32'd8);
        chk("full push_ready", {31'd0, push_ready}, 32'd0);
        cyc(1, 32'h9000, 0, 32'h0, 8'h77, 1, 0, 32'h0);
        chk("after pop count", {28'd0, count}, 32'd7);
        chk("after pop push_ready", {31'd0, push_ready}, 32'd1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);

        // Underflow is sticky until reset.
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h40);
        chk("uf err", {31'd0, err_underflow}, 32'd1);
        chk("uf no upd", {31'd0, upd_valid}, 32'd0);
        cyc(1, 32'h700, 1, 32'h800, 8'h5A, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h800);
        chk("uf err held", {31'd0, err_underflow}, 32'd1);
        do_reset();
        chk("uf err cleared", {31'd0, err_underflow}, 32'd0);

        // 20 push/resolve pairs wrapping the pointers, 3 of them mispredicted.
        for (int i = 0; i < 20; i++) begin
            pc  = 32'h4000 + 32'(i) * 16;
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFC;
            cyc(1, pc, tk, tgt, GB'($urandom), 0, 0, 32'h0);
            if (i == 4 || i == 11 || i == 17) begin
                rtk = ~tk; rtgt = tgt;
            end else begin
                rtk = tk;  rtgt = tk ? tgt : $urandom;
            end
            cyc(0, 0, 0, 0, 0, 1, rtk, rtgt);
            if (i == 4 || i == 11 || i == 17) cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
        end
`ifdef BRQ_STATS_EN
        chk("stat_branches 20", stat_branches, 32'd20);
        chk("stat_mispredicts 3", stat_mispredicts, 32'd3);
`endif

        // Random traffic against the model; resolves are mostly correct to keep the queue busy.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic rv;
            rv = ($urandom_range(0, 2) == 0);
            if (mq.size() == 0 && $urandom_range(0, 7) != 0) rv = 0;
            if (mq.size() > 0 && $urandom_range(0, 5) != 0) begin
                rtk = mq[0].tk; rtgt = mq[0].tk ? mq[0].tgt : $urandom;
            end else begin
                rtk = 1'($urandom_range(0, 1)); rtgt = $urandom & 32'hFF0;
            end
            cyc(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                $urandom & 32'hFF0, GB'($urandom), rv, rtk, rtgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracker for branch predictions in flight between fetch and execute. This is the update and recovery side of the gshare predictor.
- Fetch pushes each predicted branch: PC, predicted direction, predicted target and the GHR snapshot used for the prediction.
- Execute resolves branches in program order. The block compares the actual outcome against the oldest entry and drives the predictor update strobe.
- On a mispredict it issues a flush/redirect and discards every younger entry.

Parameters:
- DEPTH, 8: number of in-flight branch entries; power of 2, at least 2.
- GHR_BITS, 8: width of the stored global-history snapshot; must match the predictor.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous reset, active-high
- push_valid  in  1  fetch offers a predicted branch
- push_ready  out  1  queue accepts a push this cycle
- push_pc  in  32  branch PC
- push_pred_taken  in  1  predicted direction
- push_pred_target  in  32  predicted target, used only if push_pred_taken=1
- push_ghr  in  GHR_BITS  GHR value at prediction time
- resolve_valid  in  1  execute resolves the oldest branch
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual taken target
- upd_valid  out  1  one-cycle predictor update strobe
- upd_pc  out  32  PC of the resolved branch
- upd_taken  out  1  actual direction, to the predictor's actual_taken input
- upd_ghr  out  GHR_BITS  stored GHR snapshot
- mispredict  out  1  one-cycle flush pulse
- redirect_pc  out  32  correct next PC, valid while mispredict=1
- count  out  $clog2(DEPTH)+1  current occupancy
- err_underflow  out  1  sticky: a resolve arrived while the queue was empty

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Reset (synchronous, reset=1 at the clock edge): pointers=0, count=0, state=RUN, and all outputs 0 (upd_*, mispredict, redirect_pc, err_underflow). Entry contents are don't-care. Reset overrides any simultaneous push or resolve.
- Push handshake:
  - A push is accepted when push_valid && push_ready.
  - push_ready = (state==RUN) && (count<DEPTH).
  - push_ready does not depend on resolve_valid, so a full queue refuses a push even when a pop occurs in the same cycle.
- Resolve:
  - When resolve_valid && count>0, the entry at rd_ptr is popped.
  - Resolve is never back-pressured, because execute only issues branches that are present in the queue.
  - When resolve_valid && count==0: no pop, no update, and err_underflow is set to 1 and held until reset.
- Mispredict condition for the popped entry: (pred_taken != resolve_taken) || (resolve_taken && pred_target != resolve_target).
- redirect_pc = resolve_taken ? resolve_target : entry_pc + 32'd4, truncated to 32 bits so the addition wraps.
- Latency:
  - upd_valid, upd_pc, upd_taken, upd_ghr, mispredict and redirect_pc are all registered and appear 1 cycle after the resolve edge.
  - upd_valid and mispredict are high for exactly one cycle per resolve. upd_* outputs hold their values when upd_valid=0.
- Simultaneous push and correct resolve: both take effect and count is unchanged.
- Mispredict flush, applied in the resolve cycle:
  - Queue cleared: rd_ptr <= wr_ptr, count <= 0.
  - Any push in that same cycle is discarded, since the pushed branch is on the wrong path.
- State machine:
  - RUN: normal operation.
  - RUN -> RECOVER when a mispredict is detected.
  - RECOVER lasts exactly 1 cycle, which is the cycle mispredict=1. In RECOVER push_ready=0 so the frontend can apply the redirect.
  - RECOVER -> RUN unconditionally.
  - A resolve_valid asserted in RECOVER is an underflow, because the queue is empty.
- count equals the number of entries held after the last edge, ranging 0..DEPTH inclusive.

Optional Feature:
- Macro: BRQ_STATS_EN.
- When defined:
  - Adds output ports stat_branches (32 bits) and stat_mispredicts (32 bits).
  - stat_branches increments on every successful pop; stat_mispredicts increments on every mispredict.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- When undefined: neither the ports nor the counter logic exists, and the block's behaviour is otherwise identical.

Test Plan:
- Reset, then push pc=0x100 pred_taken=1 target=0x200 ghr=0xA5; resolve taken=1 target=0x200 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, upd_ghr=0xA5, mispredict=0, count=0.
- Push 8 entries back-to-back with DEPTH=8 -> count=8 and push_ready=0. Hold push_valid and resolve once correctly in the same cycle -> the push is refused, count=7, then push_ready=1.
- Push pc=0x300 pred_taken=0, then pc=0x304 and pc=0x308; resolve taken=1 target=0x400 -> mispredict=1, redirect_pc=0x400, count=0, push_ready=0 for exactly 1 cycle. A push offered in the resolve cycle is dropped.
- Push pc=0xFFFF_FFFC pred_taken=1 target=0x10; resolve taken=0 -> mispredict=1, redirect_pc=0x0000_0000 (the PC+4 addition wraps).
- Resolve with the queue empty -> no upd_valid, err_underflow=1 and it stays 1 after further correct push/resolve traffic. Assert reset -> err_underflow=0.
- Run 20 push/resolve pairs to wrap the pointers 2.5 times, with 3 mispredicts -> all upd_pc values in order. With BRQ_STATS_EN defined: stat_branches=20, stat_mispredicts=3.
